// File: rtl/memctrl_host.sv
// memctrl_host: single-beat valid/ready request -> MEMCTRL CE/CSB/WEB/OEB bus cycle initiator.
// Latency: accept at E0, ACCESS E0..E1, read data captured at E1+RD_LAT; new request every 2+R cycles.
// Backpressure: req_ready only in IDLE (requester holds req_valid); response path has no backpressure.
// Ports: CLK/RSTN (sync, active-low); req_valid/req_ready/req_we/req_addr/req_wdata request side;
//        rsp_valid/rsp_rdata read return; busy; ADDR/IDATA/CE/CSB/WEB/OEB/ODATA to MEMCTRL.
module memctrl_host #(
    parameter int RD_LAT = 1,
    parameter int GAP    = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [15:0] ADDR,
    output logic [7:0]  IDATA,
    output logic        CE,
    output logic        CSB,
    output logic        WEB,
    output logic        OEB,
    input  logic [7:0]  ODATA
);

    localparam int RMAX = (GAP > RD_LAT) ? GAP : RD_LAT;
    localparam int CW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] R_WR   = CW'(GAP);
    localparam logic [CW-1:0] R_RD   = CW'(RMAX);
    // The recovery counter is loaded with RMAX on a read, so the edge
    // E1+RD_LAT is the one where it still holds RMAX-RD_LAT+1.
    localparam logic [CW-1:0] CAP_AT = CW'(RMAX - RD_LAT + 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_t;

    state_t        state;
    logic          we_q;
    logic [CW-1:0] cnt;

    assign req_ready = (state == IDLE) & RSTN;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            cnt       <= '0;
            CE        <= 1'b0;
            CSB       <= 1'b1;
            WEB       <= 1'b1;
            OEB       <= 1'b1;
            ADDR      <= '0;
            IDATA     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // req_ready is simply "in IDLE" here since RSTN is high.
                    if (req_valid) begin
                        state <= ACCESS;
                        we_q  <= req_we;
                        CE    <= 1'b1;
                        CSB   <= 1'b0;
                        ADDR  <= req_addr;
                        WEB   <= ~req_we;
                        OEB   <= req_we;
                        IDATA <= req_we ? req_wdata : 8'h00;
                    end
                end
                ACCESS: begin
                    state <= RECOVER;
                    CE    <= 1'b0;
                    CSB   <= 1'b1;
                    WEB   <= 1'b1;
                    OEB   <= 1'b1;
                    IDATA <= '0;
                    cnt   <= we_q ? R_WR : R_RD;
                end
                RECOVER: begin
                    // ADDR intentionally left holding the last access address.
                    if (!we_q && (cnt == CAP_AT)) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ODATA;
                    end
                    if (cnt == ONE) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
